// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic-operation sequencer.
// Holds the op code encoding, the op field width and the
// sequencer FSM state encoding.
package logic_op_sequencer_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT     = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_sequencer_gate.sv
// logic_gate_bit: combinational 1-bit logic gate selected by a 3-bit op code.
// Ports:
//   op  in  3  operation select (AND, OR, NOT(A), NAND, NOR, XOR, XNOR, illegal)
//   a   in  1  operand A bit
//   b   in  1  operand B bit (unused for NOT)
//   y   out 1  result bit; 0 for the illegal op code
module logic_gate_bit
  import logic_op_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: time-shares one 1-bit gate among NUM_REQ requesters.
// A round-robin arbiter picks a requester in IDLE, its operands are captured,
// the gate is stepped LSB-first for WIDTH cycles in EXEC, and the result word
// is presented in RESP until the consumer accepts it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b  packed per-requester op code and operands
//   rsp_valid/rsp_ready result handshake
//   rsp_data/rsp_id/rsp_err  result word, source requester, illegal-op flag
//   busy                high whenever the sequencer is not idle
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int IDW     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;

  logic [OP_W-1:0]   op_arr [NUM_REQ];
  logic [WIDTH-1:0]  a_arr  [NUM_REQ];
  logic [WIDTH-1:0]  b_arr  [NUM_REQ];

  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic              gate_y;

  // Unpack the flat requester buses into per-requester slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
    assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
    assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!gnt_found && ((req_valid >> idx) & NUM_REQ'(1)) != '0) begin
        gnt_found  = 1'b1;
        gnt_idx    = IDW'(idx);
        gnt_onehot = NUM_REQ'(1) << idx;
      end
    end
  end

  logic_gate_bit u_gate (
    .op (op_q),
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .y  (gate_y)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          op_d         = op_arr[gnt_idx];
          a_d          = a_arr[gnt_idx];
          b_d          = b_arr[gnt_idx];
          rsp_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          res_d        = '0;
          if (op_arr[gnt_idx] == OP_ILLEGAL) begin
            // Illegal op skips execution; result stays all-zero.
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d[cnt_q] = gate_y;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
    end
  end

  // The grant is only offered while idle; gating with rst keeps req_ready
  // low for the whole reset pulse even if requests are pending.
  assign req_ready = (state_q == ST_IDLE && !rst) ? gnt_onehot : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = res_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_op_sequencer.sv
module tb_logic_op_sequencer;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 8;
  localparam int IDW     = 1;
  localparam int LIMIT   = 60;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [IDW-1:0]           rsp_id;
  logic                     rsp_err;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int last_m;   // reference model: index of the most recent grant

  logic_op_sequencer #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference: {err, data}
  function automatic logic [WIDTH:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      0: return {1'b0, a & b};
      1: return {1'b0, a | b};
      2: return {1'b0, ~a};
      3: return {1'b0, ~(a & b)};
      4: return {1'b0, ~(a | b)};
      5: return {1'b0, a ^ b};
      6: return {1'b0, ~(a ^ b)};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  function automatic int model_grant(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last_m + k) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]           = v;
    req_op[3*i +: 3]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // Waits for a nonzero req_ready; returns the vector and the idle cycles spent.
  // Ends at the cycle after the accept edge, #1 past the rising edge.
  task automatic wait_accept(output logic [NUM_REQ-1:0] rr, output int waited);
    rr = '0;
    waited = -1;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rr = req_ready;
        waited = n;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: no req_ready within %0d cycles, required a grant", LIMIT);
  endtask

  // Counts cycles from the first post-accept cycle until rsp_valid is seen.
  // Returns on the falling edge of the first RESP cycle.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required a response", LIMIT);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h id=%0d e=%b busy=%b, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy);
    end
    rst = 1'b0;
    last_m = NUM_REQ - 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_xor_single();
    logic [NUM_REQ-1:0] rr;
    int waited, lat;
    set_req(0, 1'b1, 3'd5, 8'hA5, 8'h0F);
    wait_accept(rr, waited);
    clear_reqs();
    checks++;
    if (rr !== onehot(0)) begin
      errors++; $display("FAIL xor_grant: req_ready=%b, required %b", rr, onehot(0));
    end
    last_m = 0;
    wait_rsp(lat);
    checks++;
    if (lat !== WIDTH + 1) begin
      errors++; $display("FAIL xor_latency: %0d cycles, required %0d", lat, WIDTH + 1);
    end
    checks++;
    if ({rsp_data, rsp_id, rsp_err} !== {8'hAA, 1'b0, 1'b0}) begin
      errors++; $display("FAIL xor_result: d=%h id=%0d e=%b, required d=aa id=0 e=0",
                         rsp_data, rsp_id, rsp_err);
    end
    ack_rsp();
    $display("txn xor: id=%0d data=%h lat=%0d", rsp_id, rsp_data, lat);
  endtask

  task automatic test_alternate();
    logic [NUM_REQ-1:0] rr;
    logic [WIDTH:0] exp;
    int waited, lat, g;
    set_req(0, 1'b1, 3'd2, 8'h3C, 8'hFF);
    set_req(1, 1'b1, 3'd4, 8'h00, 8'h01);
    for (int t = 0; t < 4; t++) begin
      g = model_grant(req_valid);
      wait_accept(rr, waited);
      checks++;
      if (rr !== onehot(g) || (t > 0 && waited !== 0)) begin
        errors++; $display("FAIL alt_grant%0d: req_ready=%b waited=%0d, required %b waited=0",
                           t, rr, waited, onehot(g));
      end
      last_m = g;
      exp = (g == 0) ? ref_op(2, 8'h3C, 8'hFF) : ref_op(4, 8'h00, 8'h01);
      wait_rsp(lat);
      checks++;
      if ({rsp_err, rsp_data} !== exp || rsp_id !== IDW'(g)) begin
        errors++; $display("FAIL alt_result%0d: d=%h id=%0d e=%b, required d=%h id=%0d e=%b",
                           t, rsp_data, rsp_id, rsp_err, exp[WIDTH-1:0], g, exp[WIDTH]);
      end
      $display("txn alt%0d: id=%0d data=%h lat=%0d", t, rsp_id, rsp_data, lat);
      ack_rsp();
    end
    clear_reqs();
  endtask

  task automatic test_illegal();
    logic [NUM_REQ-1:0] rr;
    int waited, lat;
    set_req(1, 1'b1, 3'd7, 8'hFF, 8'h12);
    wait_accept(rr, waited);
    clear_reqs();
    checks++;
    if (rr !== onehot(1)) begin
      errors++; $display("FAIL illegal_grant: req_ready=%b, required %b", rr, onehot(1));
    end
    last_m = 1;
    wait_rsp(lat);
    checks++;
    if (lat !== 1 || {rsp_data, rsp_id, rsp_err} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL illegal_result: lat=%0d d=%h id=%0d e=%b, required lat=1 d=00 id=1 e=1",
                         lat, rsp_data, rsp_id, rsp_err);
    end
    $display("txn illegal: id=%0d data=%h err=%b lat=%0d", rsp_id, rsp_data, rsp_err, lat);
    ack_rsp();
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] rr;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] exp;
    int waited, lat, g;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    set_req(0, 1'b1, 3'd0, a, b);
    g = model_grant(req_valid);
    wait_accept(rr, waited);
    set_req(0, 1'b0, 3'd0, a, b);
    set_req(1, 1'b1, 3'd1, 8'h0F, 8'h30);  // pending during EXEC and RESP
    last_m = g;
    exp = ref_op(0, a, b);
    wait_rsp(lat);
    checks++;
    if ({rsp_err, rsp_data} !== exp || rsp_id !== IDW'(g)) begin
      errors++; $display("FAIL bp_result: d=%h id=%0d e=%b, required d=%h id=%0d e=0",
                         rsp_data, rsp_id, rsp_err, exp[WIDTH-1:0], g);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== exp || rsp_id !== IDW'(g) ||
          req_ready !== '0) begin
        errors++; $display("FAIL bp_hold%0d: v=%b d=%h id=%0d e=%b rdy=%b, required v=1 d=%h id=%0d e=0 rdy=0",
                           c, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready, exp[WIDTH-1:0], g);
      end
    end
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL bp_no_grant_in_ack: req_ready=%b, required 0", req_ready);
    end
    ack_rsp();
    g = model_grant(req_valid);
    wait_accept(rr, waited);
    clear_reqs();
    checks++;
    if (rr !== onehot(g) || waited !== 0) begin
      errors++; $display("FAIL bp_next_grant: req_ready=%b waited=%0d, required %b waited=0",
                         rr, waited, onehot(g));
    end
    last_m = g;
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 8'h3F || rsp_id !== IDW'(g)) begin
      errors++; $display("FAIL bp_second_result: d=%h id=%0d, required d=3f id=%0d", rsp_data, rsp_id, g);
    end
    $display("txn backpressure: id=%0d data=%h", rsp_id, rsp_data);
    ack_rsp();
  endtask

  task automatic test_midreset();
    logic [NUM_REQ-1:0] rr;
    int waited, lat;
    bit seen;
    set_req(1, 1'b1, 3'd5, 8'h5A, 8'h33);
    wait_accept(rr, waited);
    clear_reqs();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== '0) begin
      errors++; $display("FAIL midrst_outputs: rdy=%b v=%b d=%h id=%0d e=%b busy=%b, required all 0",
                         req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = NUM_REQ - 1;
    seen = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_no_rsp: rsp_valid seen=%b, required 0", seen);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd1, 8'h01, 8'h02);
    set_req(1, 1'b1, 3'd1, 8'h10, 8'h20);
    wait_accept(rr, waited);
    clear_reqs();
    checks++;
    if (rr !== onehot(0)) begin
      errors++; $display("FAIL midrst_first_grant: req_ready=%b, required %b", rr, onehot(0));
    end
    last_m = 0;
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 8'h03 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL midrst_result: d=%h id=%0d, required d=03 id=0", rsp_data, rsp_id);
    end
    $display("txn after reset: id=%0d data=%h", rsp_id, rsp_data);
    ack_rsp();
  endtask

  task automatic test_ops();
    logic [NUM_REQ-1:0] rr;
    int waited, lat;
    logic [2:0] ops [4];
    logic [WIDTH-1:0] want [4];
    ops  = '{3'd0, 3'd1, 3'd3, 3'd6};
    want = '{8'h42, 8'hDE, 8'hBD, 8'h63};
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, ops[t], 8'hC6, 8'h5A);
      wait_accept(rr, waited);
      clear_reqs();
      last_m = 0;
      wait_rsp(lat);
      checks++;
      if (rsp_data !== want[t] || rsp_err !== 1'b0 || lat !== WIDTH + 1) begin
        errors++; $display("FAIL op%0d_result: d=%h e=%b lat=%0d, required d=%h e=0 lat=%0d",
                           ops[t], rsp_data, rsp_err, lat, want[t], WIDTH + 1);
      end
      $display("txn op%0d: data=%h", ops[t], rsp_data);
      ack_rsp();
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] rr, mask;
    logic [2:0] op_l [NUM_REQ];
    logic [WIDTH-1:0] a_l [NUM_REQ];
    logic [WIDTH-1:0] b_l [NUM_REQ];
    logic [WIDTH:0] exp;
    int waited, lat, g, want_lat;
    for (int it = 0; it < 40; it++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        op_l[i] = 3'($urandom_range(0, 7));
        a_l[i]  = WIDTH'($urandom);
        b_l[i]  = WIDTH'($urandom);
        set_req(i, mask[i], op_l[i], a_l[i], b_l[i]);
      end
      g = model_grant(mask);
      wait_accept(rr, waited);
      clear_reqs();
      checks++;
      if (rr !== onehot(g) || waited !== 0) begin
        errors++; $display("FAIL rand%0d_grant: req_ready=%b waited=%0d, required %b waited=0",
                           it, rr, waited, onehot(g));
      end
      last_m = g;
      exp = ref_op(int'(op_l[g]), a_l[g], b_l[g]);
      want_lat = (op_l[g] == 3'd7) ? 1 : WIDTH + 1;
      wait_rsp(lat);
      checks++;
      if ({rsp_err, rsp_data} !== exp || rsp_id !== IDW'(g) || lat !== want_lat) begin
        errors++; $display("FAIL rand%0d_result: d=%h id=%0d e=%b lat=%0d, required d=%h id=%0d e=%b lat=%0d",
                           it, rsp_data, rsp_id, rsp_err, lat, exp[WIDTH-1:0], g, exp[WIDTH], want_lat);
      end
      $display("txn rand%0d: op=%0d id=%0d data=%h err=%b lat=%0d", it, op_l[g], rsp_id,
               rsp_data, rsp_err, lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; @(negedge clk); end
      ack_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_xor_single();
    test_alternate();
    test_illegal();
    test_backpressure();
    test_midreset();
    test_ops();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
